pc_fetch_unit: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the single-width PC register. Holds the fetch PC and advances it by a configurable step. Accepts branch/jump redirects from execute, and stalls on either a hazard stall or an instruction-cache stall. A redirect that arrives while the unit is stalled is captured in a one-entry pending buffer rather than lost, and is applied on the first advancing cycle.

---
 rtl/pc_fetch_unit.sv | 99 +++++++++
 tb/tb_pc_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with stall handling and a one-entry pending redirect buffer.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VECTOR.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             icache_stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [XLEN-1:0]  pc_out,
    output logic             redirect_f,
    output logic             pend_valid,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [XLEN-1:0] STEP_V   = XLEN'(STEP);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            advance;
    logic            take_redirect;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] next_pc;

    assign advance = ~(hazard_stall | icache_stall);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path through the block leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        if (advance)             state_next = RUN;
        else if (redirect_valid) state_next = PEND;
    end

    always_comb begin
        pend_valid = (state == PEND);
    end

    // NOTE: the pending target is not reset; it is only ever consumed while pend_valid is set.
    always_ff @(posedge clk) begin
        if (!advance && redirect_valid) pend_target <= redirect_target;
    end

    assign take_redirect = redirect_valid | pend_valid;
    assign sel_target    = redirect_valid ? redirect_target : pend_target;

`ifdef PC_MISALIGN_TRAP_EN
    logic redirect_mis;

    always_comb begin
        redirect_mis = |(sel_target & LOW_MASK);
        redirect_pc  = redirect_mis ? TRAP_VECTOR : sel_target;
    end

    always_ff @(posedge clk) begin
        if (rst)          misalign_o <= 1'b0;
        else if (advance) misalign_o <= take_redirect & redirect_mis;
    end
`else
    assign redirect_pc = sel_target & ~LOW_MASK;
    assign misalign_o  = 1'b0;
`endif

    // Sequential fetch wraps modulo 2^XLEN through the natural adder overflow.
    assign next_pc = take_redirect ? redirect_pc : pc_out + STEP_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out      <= RESET_VECTOR;
            redirect_f  <= 1'b0;
            fetch_count <= '0;
        end else if (advance) begin
            pc_out      <= next_pc;
            redirect_f  <= take_redirect;
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios followed by random stimulus.
module tb_pc_fetch_unit;

    localparam int          STEP  = 4;
    localparam logic [31:0] RVEC  = 32'h0000_0000;
    localparam logic [31:0] TVEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        icache_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_out;
    logic        redirect_f;
    logic        pend_valid;
    logic        misalign_o;
    logic [15:0] fetch_count;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_stall    (hazard_stall),
        .icache_stall    (icache_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_out          (pc_out),
        .redirect_f      (redirect_f),
        .pend_valid      (pend_valid),
        .misalign_o      (misalign_o),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rf;
        logic        pv;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural view of the fetch PC.
    logic [31:0] m_pc;
    logic        m_rf;
    logic        m_mis;
    logic [15:0] m_cnt;
    logic [31:0] m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply_target(input logic [31:0] t);
        m_rf = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        if (t % STEP != 0) begin
            m_pc  = TVEC;
            m_mis = 1'b1;
        end else begin
            m_pc  = t;
            m_mis = 1'b0;
        end
`else
        m_pc  = t - (t % STEP);
        m_mis = 1'b0;
`endif
    endtask

    task automatic step(input logic r, input logic hs, input logic ics,
                        input logic rv, input logic [31:0] rt);
        exp_t e;
        @(negedge clk);
        #1;
        rst             = r;
        hazard_stall    = hs;
        icache_stall    = ics;
        redirect_valid  = rv;
        redirect_target = rt;
        if (r) begin
            m_pc  = RVEC;
            m_rf  = 1'b0;
            m_mis = 1'b0;
            m_cnt = '0;
            m_pend.delete();
        end else if (!(hs || ics)) begin
            m_cnt = m_cnt + 16'd1;
            if (rv) begin
                m_pend.delete();
                apply_target(rt);
            end else if (m_pend.size() != 0) begin
                apply_target(m_pend.pop_front());
            end else begin
                m_pc  = m_pc + STEP;
                m_rf  = 1'b0;
                m_mis = 1'b0;
            end
        end else if (rv) begin
            m_pend.delete();
            m_pend.push_back(rt);
        end
        e.pc  = m_pc;
        e.rf  = m_rf;
        e.pv  = (m_pend.size() != 0);
        e.mis = m_mis;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so each negedge shows the result of the previous posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_out",      pc_out,             e.pc);
                check("redirect_f",  32'(redirect_f),    32'(e.rf));
                check("pend_valid",  32'(pend_valid),    32'(e.pv));
                check("misalign_o",  32'(misalign_o),    32'(e.mis));
                check("fetch_count", 32'(fetch_count),   32'(e.cnt));
            end
        end
    end

    initial begin
        int drain;
        // Reset then four free-running cycles.
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        // Redirect with no stall, then a sequential step.
        step(0, 0, 0, 1, 32'h200);
        step(0, 0, 0, 0, 0);
        // Three-cycle icache stall with two redirects; the newer one wins.
        step(0, 0, 1, 1, 32'h300);
        step(0, 0, 1, 1, 32'h400);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Pending 0x500 dropped by a live redirect on release.
        step(0, 1, 0, 1, 32'h500);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 32'h600);
        step(0, 0, 0, 0, 0);
        // Misaligned redirect, then next advance clears the flag.
        step(0, 0, 0, 1, 32'h202);
        step(0, 0, 0, 0, 0);
        // Misaligned target captured during a stall is checked when applied.
        step(0, 1, 0, 1, 32'h33E);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Wrap at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFF8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Reset discards a pending redirect.
        step(0, 0, 1, 1, 32'h700);
        step(1, 0, 1, 1, 32'h800);
        step(0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            else if ($urandom_range(0, 1) == 0) t = t & 32'h0000_0FFF;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 t);
        end
        step(0, 0, 0, 0, 0);
        // Bounded drain of the scoreboard.
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
